// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit with data-memory handshake, store/load alignment and the MEM/WB register.
module mem_access_stage (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] ALU_result_in,
   input  logic [31:0] data_rs2_in,
   input  logic        MemWrite_in,
   input  logic        Memread_in,
   input  logic [2:0]  dm_ctrl_in,
   input  logic [4:0]  rd_in,
   input  logic        RegWrite_in,
   input  logic [1:0]  WDSel_in,
   input  logic [31:0] pc_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_o,
   output logic        RegWrite_mem_wb_out,
   output logic [4:0]  rd_mem_wb_out,
   output logic [1:0]  WDSel_mem_wb_out,
   output logic [31:0] ALU_result_mem_wb_out,
   output logic [31:0] load_data_mem_wb_out,
   output logic [31:0] pc_mem_wb_out,
   output logic        misalign_o
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state, state_nx;
   logic        is_byte, is_half, aligned, any_op, mem_op, misalign, is_load, done;
   logic [31:0] st_data, ld_shift, ld_ext;
   logic [3:0]  st_be;
   logic [15:0] ld_half;
   always_comb begin
      is_byte  = (dm_ctrl_in == 3'b011) || (dm_ctrl_in == 3'b100);
      is_half  = (dm_ctrl_in == 3'b001) || (dm_ctrl_in == 3'b010);
      aligned  = is_byte || (is_half ? !ALU_result_in[0] : (ALU_result_in[1:0] == 2'b00));
      any_op   = MemWrite_in | Memread_in;
      mem_op   = any_op & aligned;
      misalign = any_op & ~aligned;
      is_load  = mem_op & ~MemWrite_in;
   end
   // Store lanes: data is replicated so the byte enables alone pick the target lane.
   always_comb begin
      st_data = is_byte ? {4{data_rs2_in[7:0]}} : is_half ? {2{data_rs2_in[15:0]}} : data_rs2_in;
      st_be   = is_byte ? 4'b0001 << ALU_result_in[1:0] : is_half ? (ALU_result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   end
   always_comb begin
      ld_shift = dmem_rdata >> {ALU_result_in[1:0], 3'b000};
      ld_half  = ALU_result_in[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ld_ext   = (dm_ctrl_in == 3'b001) ? {{16{ld_half[15]}}, ld_half} :
                 (dm_ctrl_in == 3'b010) ? {16'h0, ld_half} :
                 (dm_ctrl_in == 3'b011) ? {{24{ld_shift[7]}}, ld_shift[7:0]} :
                 (dm_ctrl_in == 3'b100) ? {24'h0, ld_shift[7:0]} : dmem_rdata;
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx   = state;
      dmem_req   = mem_op && (state != WAIT);
      dmem_we    = dmem_req & MemWrite_in;
      dmem_addr  = dmem_req ? {ALU_result_in[31:2], 2'b00} : 32'h0;
      dmem_wdata = dmem_we ? st_data : 32'h0;
      dmem_be    = dmem_we ? st_be : 4'h0;
      done       = MemWrite_in ? (dmem_req & dmem_gnt) : ((state == WAIT) & dmem_rvalid);
      stall_o    = mem_op & ~done;
      case (state)
         IDLE, REQ: state_nx = !mem_op ? IDLE : dmem_gnt ? (MemWrite_in ? IDLE : WAIT) : REQ;
         WAIT:      state_nx = (!mem_op || dmem_rvalid) ? IDLE : WAIT;
         default:   state_nx = IDLE;
      endcase
   end
   // A stalled cycle feeds a bubble into WB so the held instruction retires exactly once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn || stall_o) begin
         RegWrite_mem_wb_out   <= 1'b0;
         rd_mem_wb_out         <= 5'h0;
         WDSel_mem_wb_out      <= 2'b00;
         ALU_result_mem_wb_out <= 32'h0;
         load_data_mem_wb_out  <= 32'h0;
         pc_mem_wb_out         <= 32'h0;
         misalign_o            <= 1'b0;
      end else begin
         RegWrite_mem_wb_out   <= RegWrite_in & ~misalign;
         rd_mem_wb_out         <= rd_in;
         WDSel_mem_wb_out      <= WDSel_in;
         ALU_result_mem_wb_out <= ALU_result_in;
         load_data_mem_wb_out  <= is_load ? ld_ext : 32'h0;
         pc_mem_wb_out         <= pc_in;
         misalign_o            <= misalign;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
   logic        clk, rstn;
   logic [31:0] ALU_result_in, data_rs2_in, pc_in, dmem_addr, dmem_wdata, dmem_rdata;
   logic        MemWrite_in, Memread_in, RegWrite_in, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, stall_o;
   logic [2:0]  dm_ctrl_in;
   logic [4:0]  rd_in, rd_mem_wb_out;
   logic [1:0]  WDSel_in, WDSel_mem_wb_out;
   logic [3:0]  dmem_be;
   logic        RegWrite_mem_wb_out, misalign_o;
   logic [31:0] ALU_result_mem_wb_out, load_data_mem_wb_out, pc_mem_wb_out;
   int          vectors = 0;
   int          errs = 0;

   mem_access_stage dut (
      .clk(clk), .rstn(rstn), .ALU_result_in(ALU_result_in), .data_rs2_in(data_rs2_in),
      .MemWrite_in(MemWrite_in), .Memread_in(Memread_in), .dm_ctrl_in(dm_ctrl_in), .rd_in(rd_in),
      .RegWrite_in(RegWrite_in), .WDSel_in(WDSel_in), .pc_in(pc_in), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall_o(stall_o),
      .RegWrite_mem_wb_out(RegWrite_mem_wb_out), .rd_mem_wb_out(rd_mem_wb_out),
      .WDSel_mem_wb_out(WDSel_mem_wb_out), .ALU_result_mem_wb_out(ALU_result_mem_wb_out),
      .load_data_mem_wb_out(load_data_mem_wb_out), .pc_mem_wb_out(pc_mem_wb_out), .misalign_o(misalign_o)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s: got %h expected %h", tag, o, e);
      end
   endtask

   task automatic chk_regs_zero(input string tag);
      chk({tag, "_rw"}, RegWrite_mem_wb_out, 0);
      chk({tag, "_rd"}, rd_mem_wb_out, 0);
      chk({tag, "_wds"}, WDSel_mem_wb_out, 0);
      chk({tag, "_alu"}, ALU_result_mem_wb_out, 0);
      chk({tag, "_ld"}, load_data_mem_wb_out, 0);
      chk({tag, "_pc"}, pc_mem_wb_out, 0);
      chk({tag, "_mis"}, misalign_o, 0);
   endtask

   task automatic idle_inputs();
      MemWrite_in = 0; Memread_in = 0; RegWrite_in = 0; dm_ctrl_in = 0; rd_in = 0;
      WDSel_in = 0; ALU_result_in = 0; data_rs2_in = 0; pc_in = 0; dmem_gnt = 0; dmem_rvalid = 0;
   endtask

   // One instruction held in EX/MEM until it retires; memory grants after dg cycles and returns data dr cycles later.
   task automatic run_op(input logic st, input logic ld, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic rw, input logic [1:0] wds,
                         input logic [31:0] pc, input int dg, input int dr, input logic [31:0] rdv);
      logic        byt, hlf, al, mem, mis, req_exp;
      logic [31:0] sel, exp_ld, exp_wd;
      logic [3:0]  exp_be;
      int          stalls, cyc;
      byt = (ctrl == 3) || (ctrl == 4);
      hlf = (ctrl == 1) || (ctrl == 2);
      al  = byt || (hlf ? (addr % 2 == 0) : (addr % 4 == 0));
      mem = (st | ld) & al;
      mis = (st | ld) & !al;
      stalls = !mem ? 0 : st ? dg : dg + dr;
      exp_ld = 0;
      if (mem && !st) begin
         if (hlf) sel = (rdv >> (16 * ((addr / 2) % 2))) & 32'hffff;
         else     sel = (rdv >> (8 * (addr % 4))) & 32'hff;
         if (ctrl == 0)      exp_ld = rdv;
         else if (ctrl == 1) exp_ld = (sel >= 32'h8000) ? sel - 32'h10000 : sel;
         else if (ctrl == 3) exp_ld = (sel >= 32'h80) ? sel - 32'h100 : sel;
         else                exp_ld = sel;
      end
      exp_be = byt ? 4'(1 << (addr % 4)) : hlf ? ((addr % 4 >= 2) ? 4'hc : 4'h3) : 4'hf;
      exp_wd = byt ? (rs2 & 32'hff) * 32'h01010101 : hlf ? (rs2 & 32'hffff) * 32'h00010001 : rs2;
      MemWrite_in = st; Memread_in = ld; dm_ctrl_in = ctrl; ALU_result_in = addr; data_rs2_in = rs2;
      rd_in = rd; RegWrite_in = rw; WDSel_in = wds; pc_in = pc; dmem_gnt = 0; dmem_rvalid = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         dmem_gnt    = mem ? (cyc == dg) : 1'($urandom % 2);
         dmem_rvalid = (mem && !st && cyc > dg) ? (cyc == dg + dr) : 1'($urandom % 2);
         dmem_rdata  = (mem && !st && cyc == dg + dr) ? rdv : $urandom;
         #1;
         chk("stall", stall_o, cyc < stalls);
         req_exp = mem && cyc <= dg;
         chk("req", dmem_req, req_exp);
         if (req_exp) begin
            chk("addr", dmem_addr, addr & 32'hfffffffc);
            chk("we", dmem_we, st);
            chk("be", dmem_be, st ? exp_be : 4'h0);
            if (st) chk("wdata", dmem_wdata, exp_wd);
         end
         @(posedge clk);
         #1;
         if (cyc < stalls) chk_regs_zero("bubble");
         else begin
            chk("rw", RegWrite_mem_wb_out, rw & !mis);
            chk("rd", rd_mem_wb_out, rd);
            chk("wds", WDSel_mem_wb_out, wds);
            chk("alu", ALU_result_mem_wb_out, addr);
            chk("ld", load_data_mem_wb_out, exp_ld);
            chk("pc", pc_mem_wb_out, pc);
            chk("mis", misalign_o, mis);
            break;
         end
      end
      if (cyc >= 40) begin
         vectors++;
         errs++;
         $error("FAIL timeout: got no retirement after %0d cycles expected %0d stalls", cyc, stalls);
      end
   endtask

   initial begin
      logic [31:0] a;
      int k;
      idle_inputs();
      dmem_rdata = 0;
      rstn = 0;
      #12;
      chk_regs_zero("reset");
      chk("reset_req", dmem_req, 0);
      chk("reset_stall", stall_o, 0);
      rstn = 1;
      @(posedge clk); #1;
      run_op(0, 0, 0, 32'h1234, 0, 5, 1, 2'b00, 32'h400, 0, 1, 0);
      run_op(1, 0, 3, 32'h103, 32'haabbccdd, 0, 0, 2'b00, 32'h404, 0, 1, 0);
      run_op(0, 1, 1, 32'h202, 0, 7, 1, 2'b01, 32'h408, 0, 1, 32'h80017fff);
      run_op(0, 1, 2, 32'h202, 0, 8, 1, 2'b01, 32'h40c, 0, 1, 32'h80017fff);
      run_op(0, 1, 0, 32'h300, 0, 9, 1, 2'b01, 32'h410, 2, 1, 32'hdeadbeef);
      run_op(0, 1, 0, 32'h006, 0, 3, 1, 2'b01, 32'h414, 0, 1, 0);
      run_op(1, 0, 1, 32'h0ff, 32'h12345678, 0, 0, 2'b00, 32'h418, 0, 1, 0);
      run_op(1, 0, 0, 32'h500, 32'h0badf00d, 0, 0, 2'b00, 32'h41c, 3, 1, 0);
      // Reset while a load sits in WAIT.
      run_op(0, 0, 0, 32'h55, 0, 4, 1, 2'b00, 32'h420, 0, 1, 0);
      MemWrite_in = 0; Memread_in = 1; dm_ctrl_in = 0; ALU_result_in = 32'h40; RegWrite_in = 1; rd_in = 6;
      @(negedge clk); dmem_gnt = 1;
      @(posedge clk); #1; dmem_gnt = 0;
      #2;
      rstn = 0;
      idle_inputs();
      #1;
      chk_regs_zero("rst_wait");
      chk("rst_wait_req", dmem_req, 0);
      chk("rst_wait_stall", stall_o, 0);
      @(negedge clk); rstn = 1; dmem_rvalid = 1; dmem_rdata = 32'hcafef00d;
      #1;
      chk("stale_rvalid_stall", stall_o, 0);
      @(posedge clk); #1;
      chk("stale_rvalid_ld", load_data_mem_wb_out, 0);
      dmem_rvalid = 0;
      run_op(0, 1, 0, 32'h40, 0, 6, 1, 2'b01, 32'h424, 0, 1, 32'h13572468);
      for (int i = 0; i < 150; i++) begin
         k = $urandom % 6;
         a = $urandom & 32'hffff;
         run_op(k == 2 || k == 3, k < 2 || k == 3, 3'($urandom % 5), a, $urandom, 5'($urandom),
                1'($urandom), 2'($urandom % 3), $urandom, $urandom % 4, 1 + $urandom % 3, $urandom);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
